odom_sample_sequencer: RTL
==========================

// Module: odom_sample_sequencer
// PURPOSE
//  Periodic scheduler for the odometry calculator datapath.
//  - Every PERIOD_CYCLES: snapshot the four wheel-speed buses and theta, start one calculator run, wait for done.
//  - Publishes the resulting pose as one coherent register set, with a valid pulse.
//  - Sits between the encoder/speed front-end and the ODOM_CALCULATOR instance in the system top.
// PARAMETERS
//  N_WIDTH        17      fixed-point bus width (speeds, theta, pose)
//  Q_WIDTH        8       fractional bits; pass-through only, no arithmetic here
//  PERIOD_CYCLES  500000  sample period in clocks (10 ms @ 50 MHz), >= 8
//  TIMEOUT_CYCLES 4096    max clocks to wait in SAMPLE or BUSY
//  CNT_W          20      width of period counter, >= clog2(PERIOD_CYCLES)
// PORTS
//  ODOM_SEQ_CLOCK_50       in   1        system clock
//  ODOM_SEQ_Reset_InLow    in   1        asynchronous reset, active low
//  ODOM_SEQ_ENABLE_In      in   1        1 = periodic sampling runs
//  ODOM_SEQ_SPDVALID_In    in   1        all four speed buses stable/valid
//  ODOM_SEQ_W1..W4_InBus   in   N_WIDTH  wheel speeds from front-end (4 ports)
//  ODOM_SEQ_THETA_InBus    in   N_WIDTH  heading from IMU path
//  ODOM_SEQ_CALCDONE_In    in   1        calculator result ready (level or pulse)
//  ODOM_SEQ_CALCX/Y/TH_InBus in N_WIDTH  calculator pose outputs (3 ports)
//  ODOM_SEQ_W1..W4_OutBus  out  N_WIDTH  latched speeds to calculator
//  ODOM_SEQ_THETA_OutBus   out  N_WIDTH  latched theta to calculator
//  ODOM_SEQ_SETBEGIN_OutLow out 1        calculator start strobe, active low
//  ODOM_SEQ_POSX/POSY/POSTH_OutBus out N_WIDTH  published pose
//  ODOM_SEQ_POSVALID_Out   out  1        1-cycle pulse when pose updated
//  ODOM_SEQ_TIMEOUT_Out    out  1        sticky: a run timed out
//  ODOM_SEQ_OVERRUN_Out    out  8        saturating count of skipped ticks
// BEHAVIOUR
//  Reset: all buses 0; SETBEGIN_OutLow = 1; POSVALID = 0; TIMEOUT = 0; OVERRUN = 0.
//  Reset: state = IDLE; period counter = 0. Reset mid-run aborts with no publish.
//  Tick: counter runs only while ENABLE=1 and wraps at PERIOD_CYCLES-1.
//    Tick is a 1-cycle pulse on wrap. ENABLE=0 clears the counter.
//  FSM IDLE -> WAIT_TICK when ENABLE=1; any state except BUSY -> IDLE when ENABLE=0.
//    BUSY always finishes or times out first.
//  WAIT_TICK -> SAMPLE on tick.
//  SAMPLE: first cycle with SPDVALID=1 latches W1..W4 and THETA.
//    -> START next cycle. Timeout -> WAIT_TICK.
//  START: SETBEGIN_OutLow=0 for exactly 1 cycle. -> BUSY.
//    Latched inputs are held stable until the next SAMPLE.
//  BUSY: CALCDONE=1 -> PUBLISH. Timeout -> WAIT_TICK, TIMEOUT set.
//    CALCDONE in the START cycle is ignored.
//  PUBLISH: pose registers <= CALC* inputs; POSVALID=1 for 1 cycle. -> WAIT_TICK.
//  Latency: tick at t, SPDVALID high -> latch t+1, SETBEGIN low t+2.
//    Done seen at d -> POSVALID and new pose at d+1.
//  Timeout: counter cleared on entering SAMPLE or BUSY.
//    Fires when count == TIMEOUT_CYCLES-1. TIMEOUT clears only on reset.
//  Overrun: tick while state != WAIT_TICK -> OVERRUN += 1, saturating at 255.
//    The skipped tick is not queued.
//  Tick and a state exit to WAIT_TICK in the same cycle: counts as an overrun.
//  Pose outputs change only in PUBLISH; never partially updated.
// STRUCTURE
//  Package odom_seq_pkg holds:
//    - state encoding localparams IDLE/WAIT_TICK/SAMPLE/START/BUSY/PUBLISH (3 bits);
//    - default N_WIDTH/Q_WIDTH constants shared with calculator and system top.
//  Sub-module odom_tick_gen: period counter with enable/clear, 1-cycle tick out.
//  Timeout counter, latches and FSM stay in this module.
// TESTING
//  1 Reset low mid-BUSY (W1=0x00100) -> all outputs at reset values, no POSVALID, state IDLE.
//  2 PERIOD=16, SPDVALID=1, W1..W4=0x00100/0x00200/0x00300/0x00400, DONE 5 cycles after start:
//    -> SETBEGIN low 2 cycles after tick; W*_OutBus hold the values;
//    -> CALCX=0x01234 appears on POSX with 1-cycle POSVALID at done+1.
//  3 SPDVALID held 0, TIMEOUT=32 -> SETBEGIN never asserted; back to WAIT_TICK after 32 cycles; TIMEOUT stays 0.
//  4 CALCDONE never asserted -> TIMEOUT=1 after 32 BUSY cycles; next tick runs normally; POS* unchanged.
//  5 PERIOD=16, DONE delay 40 -> OVERRUN increments per skipped tick; saturates at 255 in a long run.
//  6 ENABLE dropped in SAMPLE -> IDLE next cycle, no start. ENABLE dropped in BUSY -> run completes and publishes, then IDLE.

Source files
------------

// File: rtl/odom_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : odom_seq_pkg
// Purpose  : Shared constants and state encoding for the odometry sample
//            sequencer, calculator and system top.
// Revision : 1.0 - initial release
// ============================================================================
package odom_seq_pkg;

  // Default fixed-point format shared with the calculator and system top
  localparam int ODOM_N_WIDTH = 17;
  localparam int ODOM_Q_WIDTH = 8;

  // Sequencer state encoding
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_TICK = 3'd1;
  localparam logic [2:0] ST_SAMPLE    = 3'd2;
  localparam logic [2:0] ST_START     = 3'd3;
  localparam logic [2:0] ST_BUSY      = 3'd4;
  localparam logic [2:0] ST_PUBLISH   = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    WAIT_TICK = ST_WAIT_TICK,
    SAMPLE    = ST_SAMPLE,
    START     = ST_START,
    BUSY      = ST_BUSY,
    PUBLISH   = ST_PUBLISH
  } seqStateT;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [7:0] satInc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/odom_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : odom_tick_gen
// Purpose  : Free-running period counter; emits a 1-cycle tick on wrap.
//            Held at zero while disabled.
// Revision : 1.0 - initial release
// ============================================================================
module odom_tick_gen #(
  parameter int PERIOD_CYCLES = 500000,
  parameter int CNT_W         = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_enable,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PERIOD_CYCLES - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_atLast;

  assign w_atLast = (r_count == C_LAST);
  assign o_tick   = i_enable && w_atLast;

  // Period counter: cleared while disabled, wraps at the last count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!i_enable || w_atLast) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/odom_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : odom_sample_sequencer
// Purpose  : Periodic scheduler for the odometry calculator. Snapshots the
//            wheel speeds and heading each period, strobes one calculator
//            run, and publishes the resulting pose as one coherent set.
// Revision : 1.0 - initial release
// ============================================================================
module odom_sample_sequencer
  import odom_seq_pkg::*;
#(
  parameter int N_WIDTH        = ODOM_N_WIDTH,
  parameter int Q_WIDTH        = ODOM_Q_WIDTH,
  parameter int PERIOD_CYCLES  = 500000,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 20
) (
  input  logic               ODOM_SEQ_CLOCK_50,
  input  logic               ODOM_SEQ_Reset_InLow,
  input  logic               ODOM_SEQ_ENABLE_In,
  input  logic               ODOM_SEQ_SPDVALID_In,
  input  logic [N_WIDTH-1:0] ODOM_SEQ_W1_InBus,
  input  logic [N_WIDTH-1:0] ODOM_SEQ_W2_InBus,
  input  logic [N_WIDTH-1:0] ODOM_SEQ_W3_InBus,
  input  logic [N_WIDTH-1:0] ODOM_SEQ_W4_InBus,
  input  logic [N_WIDTH-1:0] ODOM_SEQ_THETA_InBus,
  input  logic               ODOM_SEQ_CALCDONE_In,
  input  logic [N_WIDTH-1:0] ODOM_SEQ_CALCX_InBus,
  input  logic [N_WIDTH-1:0] ODOM_SEQ_CALCY_InBus,
  input  logic [N_WIDTH-1:0] ODOM_SEQ_CALCTH_InBus,
  output logic [N_WIDTH-1:0] ODOM_SEQ_W1_OutBus,
  output logic [N_WIDTH-1:0] ODOM_SEQ_W2_OutBus,
  output logic [N_WIDTH-1:0] ODOM_SEQ_W3_OutBus,
  output logic [N_WIDTH-1:0] ODOM_SEQ_W4_OutBus,
  output logic [N_WIDTH-1:0] ODOM_SEQ_THETA_OutBus,
  output logic               ODOM_SEQ_SETBEGIN_OutLow,
  output logic [N_WIDTH-1:0] ODOM_SEQ_POSX_OutBus,
  output logic [N_WIDTH-1:0] ODOM_SEQ_POSY_OutBus,
  output logic [N_WIDTH-1:0] ODOM_SEQ_POSTH_OutBus,
  output logic               ODOM_SEQ_POSVALID_Out,
  output logic               ODOM_SEQ_TIMEOUT_Out,
  output logic [7:0]         ODOM_SEQ_OVERRUN_Out
);

  localparam int             TO_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  // Reject parameter sets the counters or the fixed-point format cannot hold
  if (PERIOD_CYCLES < 8 || (64'd1 << CNT_W) < 64'(PERIOD_CYCLES) ||
      TIMEOUT_CYCLES < 2 || Q_WIDTH >= N_WIDTH) begin : g_badParams
    $error("odom_sample_sequencer: illegal parameter combination");
  end

  seqStateT        r_state;
  seqStateT        w_nextState;
  logic [TO_W-1:0] r_toCount;
  logic            w_toFire;
  logic            w_tick;
  logic            w_enter;
  logic            w_capture;
  logic            w_publish;

  odom_tick_gen #(
    .PERIOD_CYCLES(PERIOD_CYCLES),
    .CNT_W        (CNT_W)
  ) u_tickGen (
    .clk     (ODOM_SEQ_CLOCK_50),
    .rst_n   (ODOM_SEQ_Reset_InLow),
    .i_enable(ODOM_SEQ_ENABLE_In),
    .o_tick  (w_tick)
  );

  assign w_toFire  = (r_toCount == C_TO_LAST);
  // Counter restarts whenever SAMPLE or BUSY is freshly entered
  assign w_enter   = (w_nextState != r_state) &&
                     (w_nextState == SAMPLE || w_nextState == BUSY);
  assign w_capture = (r_state == SAMPLE) && (w_nextState == START);
  assign w_publish = (r_state == BUSY) && ODOM_SEQ_CALCDONE_In;

  // State register
  always_ff @(posedge ODOM_SEQ_CLOCK_50 or negedge ODOM_SEQ_Reset_InLow) begin
    if (!ODOM_SEQ_Reset_InLow) r_state <= IDLE;
    else                       r_state <= w_nextState;
  end

  // Next-state decode; BUSY ignores ENABLE so a started run always resolves
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:      if (ODOM_SEQ_ENABLE_In) w_nextState = WAIT_TICK;
      WAIT_TICK: if (!ODOM_SEQ_ENABLE_In) w_nextState = IDLE;
                 else if (w_tick)         w_nextState = SAMPLE;
      SAMPLE:    if (!ODOM_SEQ_ENABLE_In)       w_nextState = IDLE;
                 else if (ODOM_SEQ_SPDVALID_In) w_nextState = START;
                 else if (w_toFire)             w_nextState = WAIT_TICK;
      START:     if (!ODOM_SEQ_ENABLE_In) w_nextState = IDLE;
                 else                     w_nextState = BUSY;
      BUSY:      if (ODOM_SEQ_CALCDONE_In) w_nextState = PUBLISH;
                 else if (w_toFire)        w_nextState = WAIT_TICK;
      PUBLISH:   w_nextState = ODOM_SEQ_ENABLE_In ? WAIT_TICK : IDLE;
      default:   w_nextState = IDLE;
    endcase
  end

  // Wait-state timeout counter, only advancing inside SAMPLE and BUSY
  always_ff @(posedge ODOM_SEQ_CLOCK_50 or negedge ODOM_SEQ_Reset_InLow) begin
    if (!ODOM_SEQ_Reset_InLow) begin
      r_toCount <= '0;
    end else if (w_enter) begin
      r_toCount <= '0;
    end else if (r_state == SAMPLE || r_state == BUSY) begin
      r_toCount <= r_toCount + 1'b1;
    end
  end

  // Input snapshot, held for the calculator until the next successful sample
  always_ff @(posedge ODOM_SEQ_CLOCK_50 or negedge ODOM_SEQ_Reset_InLow) begin
    if (!ODOM_SEQ_Reset_InLow) begin
      ODOM_SEQ_W1_OutBus    <= '0;
      ODOM_SEQ_W2_OutBus    <= '0;
      ODOM_SEQ_W3_OutBus    <= '0;
      ODOM_SEQ_W4_OutBus    <= '0;
      ODOM_SEQ_THETA_OutBus <= '0;
    end else if (w_capture) begin
      ODOM_SEQ_W1_OutBus    <= ODOM_SEQ_W1_InBus;
      ODOM_SEQ_W2_OutBus    <= ODOM_SEQ_W2_InBus;
      ODOM_SEQ_W3_OutBus    <= ODOM_SEQ_W3_InBus;
      ODOM_SEQ_W4_OutBus    <= ODOM_SEQ_W4_InBus;
      ODOM_SEQ_THETA_OutBus <= ODOM_SEQ_THETA_InBus;
    end
  end

  // Start strobe, pose publish, sticky timeout flag and overrun counter
  always_ff @(posedge ODOM_SEQ_CLOCK_50 or negedge ODOM_SEQ_Reset_InLow) begin
    if (!ODOM_SEQ_Reset_InLow) begin
      ODOM_SEQ_SETBEGIN_OutLow <= 1'b1;
      ODOM_SEQ_POSX_OutBus     <= '0;
      ODOM_SEQ_POSY_OutBus     <= '0;
      ODOM_SEQ_POSTH_OutBus    <= '0;
      ODOM_SEQ_POSVALID_Out    <= 1'b0;
      ODOM_SEQ_TIMEOUT_Out     <= 1'b0;
      ODOM_SEQ_OVERRUN_Out     <= 8'd0;
    end else begin
      ODOM_SEQ_SETBEGIN_OutLow <= (w_nextState != START);
      ODOM_SEQ_POSVALID_Out    <= w_publish;
      if (w_publish) begin
        ODOM_SEQ_POSX_OutBus  <= ODOM_SEQ_CALCX_InBus;
        ODOM_SEQ_POSY_OutBus  <= ODOM_SEQ_CALCY_InBus;
        ODOM_SEQ_POSTH_OutBus <= ODOM_SEQ_CALCTH_InBus;
      end
      if (r_state == BUSY && !ODOM_SEQ_CALCDONE_In && w_toFire) begin
        ODOM_SEQ_TIMEOUT_Out <= 1'b1;
      end
      if (w_tick && r_state != WAIT_TICK) begin
        ODOM_SEQ_OVERRUN_Out <= satInc8(ODOM_SEQ_OVERRUN_Out);
      end
    end
  end

endmodule
`default_nettype wire
